// File: rtl/frv_pipeline_writeback_if.sv
// Data-memory response channel feeding the frv writeback stage.
interface frv_pipeline_writeback_if #(
  parameter int XLEN = 32
);
  logic            dmem_recv;
  logic            dmem_ack;
  logic            dmem_error;
  logic [XLEN-1:0] dmem_rdata;

  modport master (output dmem_recv, output dmem_error, output dmem_rdata, input dmem_ack);
  modport slave  (input dmem_recv, input dmem_error, input dmem_rdata, output dmem_ack);
endinterface

// File: rtl/frv_pipeline_writeback.sv
// frv writeback stage: collects data-memory responses, aligns load data and
// retires each instruction through a registered GPR write port or a trap.
module frv_pipeline_writeback #(
  parameter int XLEN = 32
) (
  input  logic                    g_clk,
  input  logic                    g_resetn,
  frv_pipeline_writeback_if.slave dmem,
  input  logic                    flush,
  input  logic                    s4_valid,
  output logic                    s4_busy,
  input  logic [4:0]              s4_rd,
  input  logic [XLEN-1:0]         s4_opr_a,
  input  logic [XLEN-1:0]         s4_opr_b,
  input  logic [4:0]              s4_uop,
  input  logic [4:0]              s4_fu,
  input  logic                    s4_trap,
  input  logic [1:0]              s4_size,
  input  logic [31:0]             s4_instr,
  input  logic [XLEN-1:0]         mmio_rdata,
  input  logic                    mmio_error,
  output logic                    wb_valid,
  output logic                    wb_wen,
  output logic [4:0]              wb_rd,
  output logic [XLEN-1:0]         wb_wdata,
  output logic [31:0]             wb_instr,
  output logic                    trap_valid,
  output logic [5:0]              trap_cause,
  output logic [4:0]              fwd_s4_rd,
  output logic [XLEN-1:0]         fwd_s4_wdata,
  output logic                    fwd_s4_load
);

  // frv_common encodings: uop = {store, load, width[1:0], signed}
  localparam int         P_FU_LSU          = 2;
  localparam int         LSU_SIGNED        = 0;
  localparam int         LSU_LOAD          = 3;
  localparam int         LSU_STORE         = 4;
  localparam logic [1:0] LSU_BYTE          = 2'b01;
  localparam logic [1:0] LSU_HALF          = 2'b10;
  localparam logic [1:0] LSU_WORD          = 2'b11;
  localparam logic [5:0] CAUSE_LOAD_FAULT  = 6'd5;
  localparam logic [5:0] CAUSE_STORE_FAULT = 6'd7;

  typedef enum logic [1:0] {IDLE, WAIT, HAVE, DRAIN} state_t;

  function automatic logic [XLEN-1:0] align_load(
    input logic [XLEN-1:0] src,
    input logic [1:0]      off,
    input logic [1:0]      width,
    input logic            sgn
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] res;
    b = src[{off, 3'b000} +: 8];
    h = src[{off[1], 4'b0000} +: 16];
    case (width)
      LSU_BYTE: res = {{(XLEN-8){sgn & b[7]}}, b};
      LSU_HALF: res = {{(XLEN-16){sgn & h[15]}}, h};
      LSU_WORD: res = src;
      default:  res = src;
    endcase
    return res;
  endfunction

  state_t          state, state_nxt;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic            cap, clr;

  logic            dmem_recv;
  logic            lsu, mmio, mem, lsu_load, lsu_store;
  logic            ready, retire;
  logic [XLEN-1:0] src_data, load_data, wdata;
  logic            acc_err, trap;
  logic [5:0]      cause;

  logic            unused_inputs;
  assign unused_inputs = ^{s4_size, s4_opr_b[XLEN-1:2], s4_fu};

  assign dmem_recv     = dmem.dmem_recv;
  assign dmem.dmem_ack = dmem.dmem_recv;

  assign lsu       = s4_valid && s4_fu[P_FU_LSU] && !s4_trap;
  assign mmio      = s4_opr_a[4];
  assign mem       = lsu && !mmio;
  assign lsu_load  = lsu && s4_uop[LSU_LOAD];
  assign lsu_store = lsu && s4_uop[LSU_STORE];

  assign ready   = !mem || (state == HAVE) || dmem_recv;
  assign s4_busy = (s4_valid && !ready) || (state == DRAIN);
  assign retire  = s4_valid && ready && !flush && (state != DRAIN);

  // Buffered response wins over the live bus; MMIO data is used only when no mem op is present
  assign src_data  = (state == HAVE) ? rsp_data : (mem ? dmem.dmem_rdata : mmio_rdata);
  assign acc_err   = (state == HAVE) ? rsp_err  : (mem ? dmem.dmem_error : mmio_error);
  assign load_data = align_load(src_data, s4_opr_b[1:0], s4_uop[2:1], s4_uop[LSU_SIGNED]);
  assign wdata     = lsu_load ? load_data : s4_opr_a;

  always_comb begin
    trap  = 1'b0;
    cause = 6'd0;
    if (s4_trap) begin
      trap  = 1'b1;
      cause = {1'b0, s4_rd};
    end else if (lsu_load && acc_err) begin
      trap  = 1'b1;
      cause = CAUSE_LOAD_FAULT;
    end else if (lsu_store && acc_err) begin
      trap  = 1'b1;
      cause = CAUSE_STORE_FAULT;
    end
  end

  assign fwd_s4_rd    = s4_rd;
  assign fwd_s4_wdata = (lsu_load && ready) ? load_data : s4_opr_a;
  assign fwd_s4_load  = lsu_load && !ready;

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE, WAIT: begin
        if (flush) begin
          state_nxt = (state == WAIT && !dmem_recv) ? DRAIN : IDLE;
          clr       = 1'b1;
        end else if (dmem_recv) begin
          if (mem && !retire) begin
            state_nxt = HAVE;
            cap       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (mem) begin
          state_nxt = WAIT;
        end
      end
      HAVE: begin
        if (flush || retire) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end
      end
      DRAIN: begin
        if (dmem_recv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn || clr) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (cap) begin
      rsp_data <= dmem.dmem_rdata;
      rsp_err  <= dmem.dmem_error;
    end
  end

  // Retire register: results become visible the cycle after the instruction leaves s4
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wb_valid   <= 1'b0;
      wb_wen     <= 1'b0;
      wb_rd      <= 5'd0;
      wb_wdata   <= '0;
      wb_instr   <= 32'd0;
      trap_valid <= 1'b0;
      trap_cause <= 6'd0;
    end else begin
      wb_valid   <= retire;
      wb_wen     <= retire && !trap && !lsu_store && (s4_rd != 5'd0);
      trap_valid <= retire && trap;
      if (retire) begin
        wb_rd      <= s4_rd;
        wb_wdata   <= wdata;
        wb_instr   <= s4_instr;
        trap_cause <= trap ? cause : 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_frv_pipeline_writeback.sv
// Bench for frv_pipeline_writeback: directed cases plus random traffic checked
// every cycle against a behavioural model of the writeback rules.
module tb_frv_pipeline_writeback;
  localparam int XLEN = 32;
  localparam int P_FU_LSU = 2;
  localparam logic [4:0] FU_ALU = 5'b00001;
  localparam logic [4:0] FU_LSU = 5'b00100;
  localparam logic [4:0] U_LB  = 5'b01011;
  localparam logic [4:0] U_LHU = 5'b01100;
  localparam logic [4:0] U_LW  = 5'b01110;
  localparam logic [4:0] U_SW  = 5'b10110;

  logic g_clk, g_resetn, flush, s4_valid, s4_trap, mmio_error;
  logic [4:0] s4_rd, s4_uop, s4_fu;
  logic [31:0] s4_opr_a, s4_opr_b, s4_instr, mmio_rdata;
  logic [1:0] s4_size;
  logic s4_busy, wb_valid, wb_wen, trap_valid, fwd_s4_load;
  logic [4:0] wb_rd, fwd_s4_rd;
  logic [31:0] wb_wdata, wb_instr, fwd_s4_wdata;
  logic [5:0] trap_cause;

  frv_pipeline_writeback_if #(.XLEN(XLEN)) dmem_if ();

  frv_pipeline_writeback #(.XLEN(XLEN)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .dmem(dmem_if),
    .flush(flush), .s4_valid(s4_valid), .s4_busy(s4_busy), .s4_rd(s4_rd),
    .s4_opr_a(s4_opr_a), .s4_opr_b(s4_opr_b), .s4_uop(s4_uop), .s4_fu(s4_fu),
    .s4_trap(s4_trap), .s4_size(s4_size), .s4_instr(s4_instr),
    .mmio_rdata(mmio_rdata), .mmio_error(mmio_error),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .wb_instr(wb_instr), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .fwd_s4_rd(fwd_s4_rd), .fwd_s4_wdata(fwd_s4_wdata), .fwd_s4_load(fwd_s4_load)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: a flushed op still owes a response; cycles current mem op has waited
  bit          owe;
  int          age;
  logic        e_valid, e_wen, e_tv;
  logic [4:0]  e_rd;
  logic [31:0] e_wdata, e_instr;
  logic [5:0]  e_tc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] off, input logic [4:0] uop);
    int unsigned v;
    int nbytes;
    case (uop[2:1])
      2'b01:   nbytes = 1;
      2'b10:   nbytes = 2;
      default: nbytes = 4;
    endcase
    if (nbytes == 1)      v = (w >> (8 * off)) & 32'hFF;
    else if (nbytes == 2) v = (w >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
    else                  v = w;
    if (uop[0] && nbytes < 4 && v >= (32'd1 << (8 * nbytes - 1)))
      v = v - (32'd1 << (8 * nbytes));
    return v;
  endfunction

  task automatic mcheck();
    logic lsu, mem, ld, st, rdy, ret, err, trp, recv, new_owe;
    logic [31:0] src, ldv;
    logic [5:0] cause;
    chk("wb_valid", 32'(wb_valid), 32'(e_valid));
    chk("wb_wen", 32'(wb_wen), 32'(e_wen));
    chk("trap_valid", 32'(trap_valid), 32'(e_tv));
    if (e_valid) begin
      chk("wb_rd", 32'(wb_rd), 32'(e_rd));
      chk("wb_wdata", wb_wdata, e_wdata);
      chk("wb_instr", wb_instr, e_instr);
    end
    if (e_tv) chk("trap_cause", 32'(trap_cause), 32'(e_tc));
    if (!g_resetn) begin
      e_valid = 0; e_wen = 0; e_tv = 0; owe = 0; age = 0;
    end else begin
      recv = dmem_if.dmem_recv;
      lsu = s4_valid && s4_fu[P_FU_LSU] && !s4_trap;
      mem = lsu && !s4_opr_a[4];
      ld  = s4_uop[3];
      st  = s4_uop[4];
      rdy = !mem || recv;
      ret = s4_valid && rdy && !flush && !owe;
      src = mem ? dmem_if.dmem_rdata : mmio_rdata;
      ldv = m_load(src, s4_opr_b[1:0], s4_uop);
      err = mem ? dmem_if.dmem_error : mmio_error;
      if (s4_trap)               begin trp = 1; cause = {1'b0, s4_rd}; end
      else if (lsu && ld && err) begin trp = 1; cause = 6'd5; end
      else if (lsu && st && err) begin trp = 1; cause = 6'd7; end
      else                       begin trp = 0; cause = 6'd0; end
      chk("s4_busy", 32'(s4_busy), 32'((s4_valid && !rdy) || owe));
      chk("dmem_ack", 32'(dmem_if.dmem_ack), 32'(recv));
      chk("fwd_s4_load", 32'(fwd_s4_load), 32'(lsu && ld && !rdy));
      chk("fwd_s4_rd", 32'(fwd_s4_rd), 32'(s4_rd));
      if (lsu && ld) chk("fwd_s4_wdata", fwd_s4_wdata, rdy ? ldv : s4_opr_a);
      e_valid = ret;
      e_tv    = ret && trp;
      e_wen   = ret && !trp && !(lsu && st) && (s4_rd != 0);
      if (ret) begin
        e_rd = s4_rd; e_wdata = (lsu && ld) ? ldv : s4_opr_a;
        e_instr = s4_instr; e_tc = trp ? cause : 6'd0;
      end
      new_owe = owe ? !recv : (flush && mem && !recv && age > 0);
      if (ret || flush || !mem) age = 0;
      else if (!owe)            age++;
      owe = new_owe;
    end
  endtask

  task automatic step();
    @(negedge g_clk);
    mcheck();
    @(posedge g_clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] fu, input logic [4:0] uop, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic trp);
    s4_valid = 1; s4_fu = fu; s4_uop = uop; s4_rd = rd; s4_opr_a = a; s4_opr_b = b;
    s4_trap = trp; s4_instr = $urandom; s4_size = 2'($urandom_range(0, 3));
  endtask

  task automatic bus(input logic recv, input logic [31:0] rdata, input logic derr,
                     input logic [31:0] mdata, input logic merr);
    dmem_if.dmem_recv = recv; dmem_if.dmem_rdata = rdata; dmem_if.dmem_error = derr;
    mmio_rdata = mdata; mmio_error = merr;
  endtask

  task automatic drain(input int n);
    for (int j = 1; j <= n; j++) begin
      set_op(FU_ALU, 5'($urandom), 5'($urandom), $urandom, $urandom, 1'b0);
      s4_valid = 1'($urandom);
      flush = 0;
      bus(j == n, $urandom, 1'($urandom), $urandom, 1'($urandom));
      step();
    end
  endtask

  task automatic run_op(input logic [4:0] fu, input logic [4:0] uop, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic trp,
                        input int d, input int fl);
    logic is_mem;
    is_mem = fu[P_FU_LSU] && !trp && !a[4];
    set_op(fu, uop, rd, a, b, trp);
    for (int k = 0; k <= d; k++) begin
      bus(is_mem && (k == d), $urandom, ($urandom_range(0, 4) == 0), $urandom,
          ($urandom_range(0, 4) == 0));
      flush = (k == fl);
      step();
      if (k == fl) begin
        flush = 0;
        if (is_mem && k < d) drain(d - k);
        break;
      end
    end
    flush = 0;
    dmem_if.dmem_recv = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] fu, uop, rd;
    logic [31:0] a, b;
    logic trp;
    int kind, d, fl;
    g_resetn = 0; flush = 0; s4_valid = 0; s4_trap = 0;
    set_op(FU_ALU, 0, 0, 0, 0, 0); s4_valid = 0;
    bus(0, 0, 0, 0, 0);
    owe = 0; age = 0; e_valid = 0; e_wen = 0; e_tv = 0;
    e_rd = 0; e_wdata = 0; e_instr = 0; e_tc = 0;
    repeat (2) @(posedge g_clk);
    #1;
    chk("rst wb_valid", 32'(wb_valid), 0);
    chk("rst wb_wen", 32'(wb_wen), 0);
    chk("rst wb_rd", 32'(wb_rd), 0);
    chk("rst wb_wdata", wb_wdata, 0);
    chk("rst wb_instr", wb_instr, 0);
    chk("rst trap_valid", 32'(trap_valid), 0);
    chk("rst trap_cause", 32'(trap_cause), 0);
    g_resetn = 1;

    // LB at offset 3, response in the entry cycle
    set_op(FU_LSU, U_LB, 5'd10, 32'h1, 32'h2003, 0);
    bus(1, 32'h80FF_1234, 0, 32'h0, 0);
    step();
    chk("lb wen", 32'(wb_wen), 1);
    chk("lb wdata", wb_wdata, 32'hFFFF_FF80);

    // LHU, response three cycles late
    set_op(FU_LSU, U_LHU, 5'd11, 32'h3, 32'h2002, 0);
    for (int k = 0; k < 3; k++) begin
      bus(0, $urandom, 0, $urandom, 0);
      #1;
      chk("lhu busy", 32'(s4_busy), 1);
      chk("lhu fwd_load", 32'(fwd_s4_load), 1);
      step();
    end
    bus(1, 32'hBEEF_0001, 0, 32'h0, 0);
    step();
    chk("lhu wdata", wb_wdata, 32'h0000_BEEF);

    // SW with bus error
    set_op(FU_LSU, U_SW, 5'd12, 32'hF, 32'h100, 0);
    bus(1, 32'h0, 1, 32'h0, 0);
    step();
    chk("sw trap_valid", 32'(trap_valid), 1);
    chk("sw trap_cause", 32'(trap_cause), 7);
    chk("sw wen", 32'(wb_wen), 0);

    // Flush during WAIT, response two cycles after the flush
    set_op(FU_LSU, U_LW, 5'd7, 32'hF, 32'h40, 0);
    bus(0, 0, 0, 0, 0);
    step();
    flush = 1;
    step();
    flush = 0;
    set_op(FU_ALU, 5'd0, 5'd3, 32'h5555_AAAA, 32'h0, 0);
    #1;
    chk("drain busy", 32'(s4_busy), 1);
    step();
    bus(1, 32'hDEAD_BEEF, 0, 0, 0);
    step();
    chk("drain no wb_valid", 32'(wb_valid), 0);
    bus(0, 0, 0, 0, 0);
    step();
    chk("after drain wb_valid", 32'(wb_valid), 1);
    chk("after drain wdata", wb_wdata, 32'h5555_AAAA);

    // ALU with rd 0 then rd 5
    set_op(FU_ALU, 5'd0, 5'd0, 32'h1234, 32'h0, 0);
    step();
    chk("alu rd0 valid", 32'(wb_valid), 1);
    chk("alu rd0 wen", 32'(wb_wen), 0);
    set_op(FU_ALU, 5'd0, 5'd5, 32'h1234, 32'h0, 0);
    step();
    chk("alu rd5 wen", 32'(wb_wen), 1);
    chk("alu rd5 wdata", wb_wdata, 32'h1234);

    // MMIO word load, then with access error
    set_op(FU_LSU, U_LW, 5'd9, 32'h1F, 32'h8000_0000, 0);
    bus(0, 32'h0, 0, 32'hCAFE_F00D, 0);
    step();
    chk("mmio wdata", wb_wdata, 32'hCAFE_F00D);
    set_op(FU_LSU, U_LW, 5'd9, 32'h1F, 32'h8000_0000, 0);
    bus(0, 32'h0, 0, 32'hCAFE_F00D, 1);
    step();
    chk("mmio err trap_valid", 32'(trap_valid), 1);
    chk("mmio err cause", 32'(trap_cause), 5);

    // Reset while a load waits, stale response afterwards is dropped
    set_op(FU_LSU, U_LW, 5'd4, 32'hF, 32'h0, 0);
    bus(0, 0, 0, 0, 0);
    step();
    g_resetn = 0; s4_valid = 0;
    step();
    g_resetn = 1;
    bus(1, 32'h1111_2222, 0, 0, 0);
    #1;
    chk("post-reset busy", 32'(s4_busy), 0);
    step();
    bus(0, 0, 0, 0, 0);
    set_op(FU_ALU, 5'd0, 5'd6, 32'h77, 32'h0, 0);
    step();
    chk("post-reset alu", wb_wdata, 32'h77);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        s4_valid = 0;
        bus(0, $urandom, 1'($urandom), $urandom, 1'($urandom));
        step();
      end
      kind = $urandom_range(0, 5);
      rd = 5'($urandom); b = $urandom; trp = 0; d = 0;
      case (kind)
        0, 1: begin fu = FU_ALU; uop = 5'($urandom); a = $urandom; end
        2: begin
          fu = 5'b00001 << $urandom_range(0, 4); uop = 5'($urandom); a = $urandom; trp = 1;
        end
        3: begin
          fu = FU_LSU; uop = {2'b01, 2'($urandom_range(1, 3)), 1'($urandom)};
          a = 32'($urandom_range(0, 15)); d = $urandom_range(0, 3);
        end
        4: begin
          fu = FU_LSU; uop = {2'b10, 2'($urandom_range(1, 3)), 1'b0};
          a = 32'($urandom_range(0, 15)); d = $urandom_range(0, 3);
        end
        default: begin
          fu = FU_LSU;
          uop = $urandom_range(0, 1) ? {2'b01, 2'($urandom_range(1, 3)), 1'($urandom)}
                                     : {2'b10, 2'($urandom_range(1, 3)), 1'b0};
          a = 32'h10 | 32'($urandom_range(0, 15));
        end
      endcase
      if (d == 0) fl = ($urandom_range(0, 4) == 0) ? 0 : -1;
      else        fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, d) : -1;
      run_op(fu, uop, rd, a, b, trp, d, fl);
    end
    s4_valid = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/frv_pipeline_writeback.md
# frv_pipeline_writeback

Final (writeback) stage of the frv pipeline, directly downstream of the memory stage. It accepts the s4 pipeline payload and waits for data-memory responses to LSU operations. It aligns and sign/zero-extends load data and selects MMIO read data for MMIO accesses. It then retires each instruction through a registered GPR write port, or raises a trap.

## Interface
- XLEN, 32: datapath width. XL = XLEN-1.
- g_clk  in  1  clock.
- g_resetn  in  1  synchronous, active-low reset.
- flush  in  1  discard the current s4 instruction.
- s4_valid  in  1  payload valid.
- s4_busy  out  1  stage cannot accept or retire this cycle.
- s4_rd  in  5  destination register, or trap cause when s4_trap is set.
- s4_opr_a  in  XLEN  result data; for LSU ops, {27'b0, mmio, strb[3:0]}.
- s4_opr_b  in  XLEN  for LSU ops, the byte address.
- s4_uop, s4_fu  in  5, 5  micro-op and one-hot FU; LSU_* and P_FU_LSU encodings from frv_common.vh.
- s4_trap  in  1  upstream trap.
- s4_size, s4_instr  in  2, 32  passed to the retire outputs.
- dmem_recv  in  1  response valid.
- dmem_ack  out  1  response accepted.
- dmem_error  in  1  bus error.
- dmem_rdata  in  XLEN  read word.
- mmio_rdata  in  XLEN  MMIO read data, valid while an MMIO op sits in s4.
- mmio_error  in  1  MMIO access error.
- wb_valid  out  1  one instruction retired last cycle.
- wb_wen  out  1  GPR write.
- wb_rd  out  5  GPR address.
- wb_wdata  out  XLEN  GPR data.
- wb_instr  out  32  retired instruction word.
- trap_valid  out  1  retired instruction traps.
- trap_cause  out  6  trap cause.
- fwd_s4_rd  out  5  forwarding: destination register (= s4_rd).
- fwd_s4_wdata  out  XLEN  forwarding: data for this stage.
- fwd_s4_load  out  1  forwarding: load still pending in this stage.

## Operation
- Classification: lsu = s4_valid && s4_fu[P_FU_LSU] && !s4_trap.
  - mmio = s4_opr_a[4].
  - mem = lsu && !mmio.
- States:
  - IDLE
  - WAIT: mem op present, no response yet.
  - HAVE: response captured in the 1-entry buffer, rsp_data/rsp_err.
  - DRAIN: a flushed mem op still owes a response.
- Transitions:
  - IDLE→WAIT: mem && !dmem_recv.
  - IDLE/WAIT, when dmem_recv and the op retires that cycle: → IDLE.
  - IDLE/WAIT, when dmem_recv but retire is blocked: → HAVE, capturing the response.
  - HAVE→IDLE: on retire.
  - WAIT + flush without dmem_recv: → DRAIN.
  - DRAIN→IDLE: on dmem_recv; that response is discarded.
- Flush in IDLE/HAVE: → IDLE, buffer cleared.
- dmem_ack = dmem_recv; responses are always accepted.
- A response arriving in IDLE with no mem op is dropped.
- ready = !mem || state==HAVE || dmem_recv.
- s4_busy = (s4_valid && !ready) || state==DRAIN.
- Retire = s4_valid && ready && !flush && state!=DRAIN.
- Load data: src = rsp_data if HAVE, else dmem_rdata if mem, else mmio_rdata. off = s4_opr_b[1:0].
  - byte: src[8*off+:8].
  - half: src[16*off[1]+:16].
  - word: src.
  - LSU_SIGNED sign-extends, otherwise zero-extends.
- Trap priority:
  - s4_trap: cause = {1'b0, s4_rd}.
  - Else load with error (dmem or mmio): cause 5, load access fault.
  - Else store with error: cause 7, store access fault.
- GPR write: wb_wen = retire && !trap && !lsu_store && rd!=0. Data is the aligned load data for loads, s4_opr_a otherwise.
- Forwarding:
  - fwd_s4_wdata = aligned load data when ready, else s4_opr_a.
  - fwd_s4_load = lsu && load && !ready.

## Timing
- Reset: state IDLE, buffer 0. All wb_* outputs, trap_valid and trap_cause are 0.
- Retire outputs are registered and appear on the cycle after retire. wb_valid is a 1-cycle pulse per instruction. When not retiring, wb_valid, wb_wen and trap_valid are 0.
- Latency:
  - Non-LSU, trap and MMIO: retire in the entry cycle.
  - mem op: retires in the cycle dmem_recv arrives, or the cycle after if buffered.
- No combinational path from dmem_recv to dmem_ack other than the identity.
- flush takes priority over retire in the same cycle. Reset mid-WAIT returns to IDLE.

## Test plan
- LB, addr 0x2003, dmem_rdata 0x80FF_1234, recv same cycle → next cycle wb_wen=1, wb_wdata=0xFFFF_FF80.
- LHU, addr 0x2002, rdata 0xBEEF_0001, recv 3 cycles late → s4_busy=1 for 3 cycles, fwd_s4_load=1, then wb_wdata=0x0000_BEEF.
- SW with dmem_error=1 → trap_valid=1, trap_cause=7, wb_wen=0.
- Flush during WAIT, response 2 cycles later → state DRAIN, s4_busy=1; response dropped, no wb_valid; next ALU op retires normally.
- ALU op, rd=0, s4_opr_a=0x1234 → wb_valid=1, wb_wen=0; rd=5 → wb_wen=1, wb_wdata=0x1234.
- MMIO LW, s4_opr_a=0x1F, mmio_rdata=0xCAFE_F00D → retires same cycle, wb_wdata=0xCAFE_F00D; with mmio_error=1 → trap_cause=5.
